serial_word_sender: RTL and testbench
=====================================

# serial_word_sender

Parallel-in/serial-out stage that drives the team's 16:1 mux. It accepts a 16-bit word over a valid/ready handshake, holds it, and steps a 4-bit select counter through all 16 mux inputs. It emits one bit per beat on a valid/ready serial port and flags the final bit. It sits directly upstream of the mux: it owns both the mux data bus and select lines, and consumes the mux output.

## Interface
- `MSB_FIRST`, default 0: 0 emits bit 0 first; 1 emits bit 15 first.
- `clk` in 1: single clock, all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream word available.
- `in_data` in 16: word to serialize, sampled on accept.
- `in_ready` out 1: stage can accept a word this cycle.
- `ser_valid` out 1: `ser_out` holds a valid bit.
- `ser_out` out 1: current serial bit, taken from the mux output.
- `ser_last` out 1: current bit is the 16th of the word.
- `ser_ready` in 1: downstream takes the bit this cycle.
- `sel_dbg` out 4: mux select currently applied, for observability.

## Operation
- State machine with two states: `IDLE` and `SEND`.
  - Registers: `word[15:0]`, `idx[3:0]`.
- Mux wiring: mux data input is `word`. Mux select is `idx` when `MSB_FIRST=0`, and `~idx` when `MSB_FIRST=1`. `sel_dbg` equals the applied select.
- `in_ready` is combinational: `!rst && (state==IDLE || (state==SEND && ser_last && ser_ready))`.
- Accept occurs when `in_valid && in_ready`. On accept: `word <= in_data`, `idx <= 0`, `state <= SEND`.
- In `SEND`:
  - `ser_valid` is 1.
  - `ser_out` is the mux output.
  - `ser_last` is `(idx==15)`.
- A beat completes when `ser_valid && ser_ready`.
  - Not last: `idx <= idx+1`.
  - Last, with no new accept: `state <= IDLE`, `idx <= 0`.
  - Last, with a simultaneous accept: load the new word, `idx <= 0`, remain in `SEND`. There is no bubble.
- `ser_ready` low stalls the stage. `idx`, `word`, `ser_out` and `ser_last` stay stable, and `ser_valid` stays high. The stage never withdraws a valid bit.
- In `IDLE`: `ser_valid`, `ser_out` and `ser_last` are all 0. `ser_out` is gated, not a mux passthrough.
- `in_data` is ignored at all times other than the accept cycle. Changing it mid-word has no effect.
- `idx` never wraps on its own. Reaching 15 always ends the word or reloads it.

## Timing
- Reset values:
  - `state=IDLE`, `word=0`, `idx=0`.
  - `ser_valid=0`, `ser_out=0`, `ser_last=0`, `sel_dbg=0`.
  - `in_ready=0` while `rst` is high.
- Latency: accept at edge N. The first bit is valid from cycle N+1.
- Throughput with `ser_ready` held high: 16 cycles per word. Back-to-back words produce a continuous `ser_valid`.
- Reset mid-word: on the next edge the stage is in `IDLE` and the remaining bits are discarded. No `ser_last` is produced for the aborted word.
- Reset takes priority over accept and over beat completion in the same cycle.

## Structure
- Shared package holds:
  - State encoding constants `ST_IDLE=1'b0` and `ST_SEND=1'b1`.
  - `LAST_IDX=4'd15`.
- One sub-module instance: the existing `Mux_16x1`, with `I=word`, `S=applied select` and `O` driving `ser_out` before gating.
- The FSM, counter and handshake logic live in this block.

## Test plan
- Reset then idle. Apply `rst=1` for 2 cycles, then release.
  - Required: `in_ready=1`, `ser_valid=0`, `ser_out=0`.
- Single word, LSB first. Send `in_data=16'hA5C3` with `ser_ready=1`.
  - Required bit sequence: 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - `ser_last` is high only on beat 16.
  - Returns to `IDLE` on cycle 17.
- MSB first. With `MSB_FIRST=1`, send `16'h8001`.
  - Required: first bit 1, bits 2–15 are 0, last bit 1.
  - `sel_dbg` runs 15 down to 0.
- Backpressure. Send `16'h0004` and hold `ser_ready=0` for 5 cycles at `idx=2`.
  - Required: `ser_out=1`, `ser_valid=1` and `sel_dbg=2` all stay stable throughout.
  - The sequence resumes correctly when `ser_ready` returns high.
- Back-to-back. Send `16'hFFFF`, then `16'h0000`, with `in_valid` held high.
  - Required: `in_ready` pulses only on the last-beat cycle.
  - Output is 32 continuous valid beats: sixteen 1s then sixteen 0s.
- Reset mid-word. Send `16'hFFFF` and assert `rst` at beat 7.
  - Required: next cycle shows `ser_valid=0` and no `ser_last`.
  - A following word `16'h0001` serializes correctly from bit 0.

Source files
------------

// File: rtl/serial_word_sender_pkg.sv
// Shared types and constants for the serial word sender.
package serial_word_sender_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned IDX_W  = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/serial_word_sender_if.sv
// Word-in / bit-out handshake bundle plus mux-select observability.
interface serial_word_sender_if;
  import serial_word_sender_pkg::*;

  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic              ser_valid;
  logic              ser_out;
  logic              ser_last;
  logic              ser_ready;
  logic [IDX_W-1:0]  sel_dbg;

  modport master (
    input  in_valid, in_data, ser_ready,
    output in_ready, ser_valid, ser_out, ser_last, sel_dbg
  );

  modport slave (
    output in_valid, in_data, ser_ready,
    input  in_ready, ser_valid, ser_out, ser_last, sel_dbg
  );
endinterface

// File: rtl/Mux_16x1.sv
// 16:1 single-bit multiplexer selecting I[S].
module Mux_16x1 (
  input  logic [15:0] I,
  input  logic [3:0]  S,
  output logic        O
);
  assign O = I[S];
endmodule

// File: rtl/serial_word_sender.sv
// Parallel-in/serial-out stage: holds a 16-bit word and walks the mux select
// across it, emitting one bit per accepted beat.
module serial_word_sender
  import serial_word_sender_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_word_sender_if.master bus
);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic               sel;
  logic [IDX_W-1:0]   mux_sel;
  logic               mux_o;
  logic               ser_valid_c;
  logic               ser_last_c;
  logic               in_ready_c;
  logic               accept_c;
  logic               beat_c;

  assign mux_sel = MSB_FIRST ? ~idx_q : idx_q;
  assign sel     = 1'b0;

  Mux_16x1 u_mux (
    .I (word_q),
    .S (mux_sel),
    .O (mux_o)
  );

  // Handshake qualifiers and next-state logic.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    ser_valid_c = (state_q == ST_SEND);
    ser_last_c  = ser_valid_c && (idx_q == LAST_IDX);
    beat_c      = ser_valid_c && bus.ser_ready;
    in_ready_c  = !rst && ((state_q == ST_IDLE) || (ser_last_c && bus.ser_ready));
    accept_c    = bus.in_valid && in_ready_c;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          word_d  = bus.in_data;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (beat_c) begin
          if (!ser_last_c) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (accept_c) begin
            word_d = bus.in_data;
            idx_d  = '0;
          end else begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
    end
  end

  // Serial output is forced low outside SEND rather than exposing the mux.
  assign bus.in_ready  = in_ready_c;
  assign bus.ser_valid = ser_valid_c;
  assign bus.ser_out   = ser_valid_c & mux_o & ~sel;
  assign bus.ser_last  = ser_last_c;
  assign bus.sel_dbg   = mux_sel;

endmodule

// File: tb/tb_serial_word_sender.sv
// Directed bench for serial_word_sender: LSB-first and MSB-first instances.
module tb_serial_word_sender;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  serial_word_sender_if b0 ();
  serial_word_sender_if b1 ();

  serial_word_sender #(.MSB_FIRST(1'b0)) u_dut_lsb (.clk(clk), .rst(rst), .bus(b0.master));
  serial_word_sender #(.MSB_FIRST(1'b1)) u_dut_msb (.clk(clk), .rst(rst), .bus(b1.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached before end of test");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Checks one LSB-instance beat at the falling edge.
  task automatic chk_beat0(input string tag, input logic bit_exp, input logic last_exp,
                           input logic [3:0] sel_exp);
    @(negedge clk);
    check_eq({tag, "_valid"}, 16'(b0.ser_valid), 16'd1);
    check_eq({tag, "_out"},   16'(b0.ser_out),   16'(bit_exp));
    check_eq({tag, "_last"},  16'(b0.ser_last),  16'(last_exp));
    check_eq({tag, "_sel"},   16'(b0.sel_dbg),   16'(sel_exp));
  endtask

  // Presents a word to the LSB instance for exactly one accept cycle.
  task automatic accept0(input logic [15:0] w);
    b0.in_valid = 1'b1;
    b0.in_data  = w;
    @(negedge clk);
    check_eq("accept_in_ready", 16'(b0.in_ready), 16'd1);
    next_cycle();
    b0.in_valid = 1'b0;
    b0.in_data  = ~w;
  endtask

  logic [15:0] w;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    b0.in_valid = 1'b0; b0.in_data = '0; b0.ser_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.ser_ready = 1'b1;

    // Reset then idle
    next_cycle();
    @(negedge clk);
    check_eq("rst_in_ready", 16'(b0.in_ready), 16'd0);
    check_eq("rst_valid", 16'(b0.ser_valid), 16'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_in_ready", 16'(b0.in_ready), 16'd1);
    check_eq("idle_valid", 16'(b0.ser_valid), 16'd0);
    check_eq("idle_out", 16'(b0.ser_out), 16'd0);
    check_eq("idle_last", 16'(b0.ser_last), 16'd0);
    check_eq("idle_sel", 16'(b0.sel_dbg), 16'd0);
    next_cycle();

    // Single word, LSB first: A5C3 -> 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
    w = 16'b1010_0101_1100_0011;
    accept0(16'hA5C3);
    for (int b = 0; b < 16; b++) begin
      chk_beat0($sformatf("a5c3_b%0d", b), w[b], logic'(b == 15), 4'(b));
      next_cycle();
    end
    @(negedge clk);
    check_eq("a5c3_end_valid", 16'(b0.ser_valid), 16'd0);
    check_eq("a5c3_end_out", 16'(b0.ser_out), 16'd0);
    check_eq("a5c3_end_in_ready", 16'(b0.in_ready), 16'd1);
    next_cycle();

    // MSB first on the second instance: 8001
    b1.in_valid = 1'b1;
    b1.in_data  = 16'h8001;
    @(negedge clk);
    check_eq("msb_in_ready", 16'(b1.in_ready), 16'd1);
    next_cycle();
    b1.in_valid = 1'b0;
    b1.in_data  = 16'hFFFF;
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      check_eq($sformatf("msb_b%0d_valid", b), 16'(b1.ser_valid), 16'd1);
      check_eq($sformatf("msb_b%0d_out", b), 16'(b1.ser_out), 16'((b == 0) || (b == 15)));
      check_eq($sformatf("msb_b%0d_last", b), 16'(b1.ser_last), 16'(b == 15));
      check_eq($sformatf("msb_b%0d_sel", b), 16'(b1.sel_dbg), 16'(15 - b));
      next_cycle();
    end
    @(negedge clk);
    check_eq("msb_end_valid", 16'(b1.ser_valid), 16'd0);
    next_cycle();

    // Backpressure: 0004, stall 5 cycles at idx 2
    accept0(16'h0004);
    for (int b = 0; b < 16; b++) begin
      if (b == 2) begin
        b0.ser_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check_eq($sformatf("stall%0d_out", s), 16'(b0.ser_out), 16'd1);
          check_eq($sformatf("stall%0d_valid", s), 16'(b0.ser_valid), 16'd1);
          check_eq($sformatf("stall%0d_sel", s), 16'(b0.sel_dbg), 16'd2);
          check_eq($sformatf("stall%0d_last", s), 16'(b0.ser_last), 16'd0);
          next_cycle();
        end
        b0.ser_ready = 1'b1;
      end
      chk_beat0($sformatf("bp_b%0d", b), logic'(b == 2), logic'(b == 15), 4'(b));
      next_cycle();
    end
    @(negedge clk);
    check_eq("bp_end_valid", 16'(b0.ser_valid), 16'd0);
    next_cycle();

    // Back-to-back FFFF then 0000 with in_valid held
    b0.in_valid = 1'b1;
    b0.in_data  = 16'hFFFF;
    @(negedge clk);
    check_eq("b2b_first_in_ready", 16'(b0.in_ready), 16'd1);
    next_cycle();
    b0.in_data = 16'h0000;
    for (int b = 0; b < 16; b++) begin
      chk_beat0($sformatf("b2b_w0_b%0d", b), 1'b1, logic'(b == 15), 4'(b));
      check_eq($sformatf("b2b_w0_b%0d_in_ready", b), 16'(b0.in_ready), 16'(b == 15));
      next_cycle();
    end
    b0.in_valid = 1'b0;
    b0.in_data  = 16'h5555;
    for (int b = 0; b < 16; b++) begin
      chk_beat0($sformatf("b2b_w1_b%0d", b), 1'b0, logic'(b == 15), 4'(b));
      next_cycle();
    end
    @(negedge clk);
    check_eq("b2b_end_valid", 16'(b0.ser_valid), 16'd0);
    next_cycle();

    // Reset mid-word at beat 7
    accept0(16'hFFFF);
    for (int b = 0; b < 7; b++) begin
      chk_beat0($sformatf("rmw_b%0d", b), 1'b1, 1'b0, 4'(b));
      next_cycle();
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("rmw_rst_in_ready", 16'(b0.in_ready), 16'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rmw_after_valid", 16'(b0.ser_valid), 16'd0);
    check_eq("rmw_after_last", 16'(b0.ser_last), 16'd0);
    check_eq("rmw_after_sel", 16'(b0.sel_dbg), 16'd0);
    check_eq("rmw_after_in_ready", 16'(b0.in_ready), 16'd1);
    next_cycle();
    accept0(16'h0001);
    for (int b = 0; b < 16; b++) begin
      chk_beat0($sformatf("rmw_w1_b%0d", b), logic'(b == 0), logic'(b == 15), 4'(b));
      next_cycle();
    end
    @(negedge clk);
    check_eq("rmw_end_valid", 16'(b0.ser_valid), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
